dmem_port_ws: RTL and testbench

DMEM_PORT_WS -- requirements
Module: dmem_port_ws

---
 rtl/dmem_port_ws.sv | 247 ++++++++++++++++++++++++
 tb/tb_dmem_port_ws.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ws.sv
// ---------------------------------------------------------------------------
// dmem_port_ws
// CPU-side data-memory port with a fixed number of memory wait states.
// A request is accepted only while idle. Aligned loads and stores run one
// ACCESS phase of WAIT_CYCLES cycles. Misaligned requests and no-op requests
// (neither read nor write) skip memory and answer at once. Every request ends
// with a single RESP cycle that pulses 'good'.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   addr, valid         : CPU byte address and request strobe
//   memRead, memWrite   : request type (both high is taken as a write)
//   writeData           : store data, low-aligned
//   maskMode            : 0 byte, 1 half, 2/3 word
//   sext                : sign-extend loaded byte/half when 1
//   good, misalign      : one-cycle completion / alignment-error pulses
//   readData            : extended load result, held until the next RESP
//   dmAddr_out          : word-aligned memory address
//   dmData_out          : lane-replicated store data
//   dmData_in           : memory read data
//   dmMem_r, dmMem_w    : memory read strobe and write byte enables
// ---------------------------------------------------------------------------
module dmem_port_ws #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              valid,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [31:0]       writeData,
    input  logic [1:0]        maskMode,
    input  logic              sext,
    output logic              good,
    output logic [31:0]       readData,
    output logic              misalign,
    output logic [ADDR_W-1:0] dmAddr_out,
    output logic [31:0]       dmData_out,
    input  logic [31:0]       dmData_in,
    output logic              dmMem_r,
    output logic [3:0]        dmMem_w
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // ACCESS lasts WAIT_CYCLES cycles: the counter starts at WAIT_CYCLES-1
    // and the phase ends on the edge where it reads zero.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    // Half needs an even address, word needs a multiple of four.
    function automatic logic is_aligned(input logic [1:0] mode, input logic [1:0] lo);
        logic ok;
        case (mode)
            2'd0:    ok = 1'b1;
            2'd1:    ok = (lo[0] == 1'b0);
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] mode, input logic [1:0] lo);
        logic [3:0] be;
        case (mode)
            2'd0:    be = 4'b0001 << lo;
            2'd1:    be = 4'b0011 << lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated into every lane so the byte enables alone
    // select which lane the memory really writes.
    function automatic logic [31:0] store_lanes(input logic [1:0] mode, input logic [31:0] data);
        logic [31:0] d;
        case (mode)
            2'd0:    d = {4{data[7:0]}};
            2'd1:    d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0]  mode,
                                                 input logic [1:0]  lo,
                                                 input logic        sx,
                                                 input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        case (mode)
            2'd0:    r = {{24{sx & b[7]}}, b};
            2'd1:    r = {{16{sx & h[15]}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [3:0]          cnt_r, cnt_nxt_s;
    logic [1:0]          addr_lo_r, addr_lo_nxt_s;
    logic [1:0]          mode_r, mode_nxt_s;
    logic                sext_r, sext_nxt_s;
    logic                write_r, write_nxt_s;
    logic                good_r, good_nxt_s;
    logic                misalign_r, misalign_nxt_s;
    logic [31:0]         rdata_r, rdata_nxt_s;
    logic [ADDR_W-1:0]   dm_addr_r, dm_addr_nxt_s;
    logic [31:0]         dm_dout_r, dm_dout_nxt_s;
    logic                dm_rd_r, dm_rd_nxt_s;
    logic [3:0]          dm_we_r, dm_we_nxt_s;

    // Next-state and next-output decode for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        addr_lo_nxt_s  = addr_lo_r;
        mode_nxt_s     = mode_r;
        sext_nxt_s     = sext_r;
        write_nxt_s    = write_r;
        good_nxt_s     = 1'b0;
        misalign_nxt_s = 1'b0;
        rdata_nxt_s    = rdata_r;
        dm_addr_nxt_s  = dm_addr_r;
        dm_dout_nxt_s  = dm_dout_r;
        dm_rd_nxt_s    = 1'b0;
        dm_we_nxt_s    = 4'b0000;

        case (state_r)
            ST_IDLE: begin
                if (valid) begin
                    if (!(memRead | memWrite)) begin
                        state_nxt_s = ST_RESP;
                        good_nxt_s  = 1'b1;
                        rdata_nxt_s = 32'h0000_0000;
                    end else if (!is_aligned(maskMode, addr[1:0])) begin
                        state_nxt_s    = ST_RESP;
                        good_nxt_s     = 1'b1;
                        misalign_nxt_s = 1'b1;
                        rdata_nxt_s    = 32'h0000_0000;
                    end else begin
                        state_nxt_s   = ST_ACCESS;
                        cnt_nxt_s     = CNT_INIT;
                        addr_lo_nxt_s = addr[1:0];
                        mode_nxt_s    = maskMode;
                        sext_nxt_s    = sext;
                        write_nxt_s   = memWrite;
                        dm_addr_nxt_s = {addr[ADDR_W-1:2], 2'b00};
                        // Strobes are registered here so they are already
                        // high during the first ACCESS cycle.
                        if (memWrite) begin
                            dm_we_nxt_s   = byte_enables(maskMode, addr[1:0]);
                            dm_dout_nxt_s = store_lanes(maskMode, writeData);
                        end else begin
                            dm_rd_nxt_s = 1'b1;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    // Final ACCESS edge: strobes drop, read data is captured.
                    state_nxt_s = ST_RESP;
                    good_nxt_s  = 1'b1;
                    if (write_r) begin
                        rdata_nxt_s = 32'h0000_0000;
                    end else begin
                        rdata_nxt_s = load_extract(mode_r, addr_lo_r, sext_r, dmData_in);
                    end
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                    dm_rd_nxt_s = dm_rd_r;
                    dm_we_nxt_s = dm_we_r;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= 4'd0;
            addr_lo_r  <= 2'b00;
            mode_r     <= 2'b00;
            sext_r     <= 1'b0;
            write_r    <= 1'b0;
            good_r     <= 1'b0;
            misalign_r <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            dm_addr_r  <= '0;
            dm_dout_r  <= 32'h0000_0000;
            dm_rd_r    <= 1'b0;
            dm_we_r    <= 4'b0000;
        end else begin
            cnt_r      <= cnt_nxt_s;
            addr_lo_r  <= addr_lo_nxt_s;
            mode_r     <= mode_nxt_s;
            sext_r     <= sext_nxt_s;
            write_r    <= write_nxt_s;
            good_r     <= good_nxt_s;
            misalign_r <= misalign_nxt_s;
            rdata_r    <= rdata_nxt_s;
            dm_addr_r  <= dm_addr_nxt_s;
            dm_dout_r  <= dm_dout_nxt_s;
            dm_rd_r    <= dm_rd_nxt_s;
            dm_we_r    <= dm_we_nxt_s;
        end
    end

    assign good       = good_r;
    assign misalign   = misalign_r;
    assign readData   = rdata_r;
    assign dmAddr_out = dm_addr_r;
    assign dmData_out = dm_dout_r;
    assign dmMem_r    = dm_rd_r;
    assign dmMem_w    = dm_we_r;

endmodule

// File: tb/tb_dmem_port_ws.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_ws
// Three instances of dmem_port_ws (WAIT_CYCLES = 1, 3, 4) share clock and
// reset. Each transaction drives one instance. A reference model derives the
// byte enables, store lanes, load result and timing from the access size and
// the byte offset.
// ---------------------------------------------------------------------------
module tb_dmem_port_ws;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_a   [ND];
    logic        valid_a  [ND];
    logic        rd_a     [ND];
    logic        wr_a     [ND];
    logic [31:0] wdata_a  [ND];
    logic [1:0]  mode_a   [ND];
    logic        sext_a   [ND];
    logic        good_a   [ND];
    logic [31:0] rdata_a  [ND];
    logic        mis_a    [ND];
    logic [31:0] dmaddr_a [ND];
    logic [31:0] dmdout_a [ND];
    logic [31:0] dmdin_a  [ND];
    logic        dmr_a    [ND];
    logic [3:0]  dmw_a    [ND];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_addr [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_port_ws #(
            .ADDR_W      (32),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .addr       (addr_a[g]),
            .valid      (valid_a[g]),
            .memRead    (rd_a[g]),
            .memWrite   (wr_a[g]),
            .writeData  (wdata_a[g]),
            .maskMode   (mode_a[g]),
            .sext       (sext_a[g]),
            .good       (good_a[g]),
            .readData   (rdata_a[g]),
            .misalign   (mis_a[g]),
            .dmAddr_out (dmaddr_a[g]),
            .dmData_out (dmdout_a[g]),
            .dmData_in  (dmdin_a[g]),
            .dmMem_r    (dmr_a[g]),
            .dmMem_w    (dmw_a[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int d);
        valid_a[d] = 1'b0;
        rd_a[d]    = 1'b0;
        wr_a[d]    = 1'b0;
        addr_a[d]  = 32'h0;
        wdata_a[d] = 32'h0;
        mode_a[d]  = 2'd0;
        sext_a[d]  = 1'b0;
        dmdin_a[d] = 32'h0;
    endtask

    // Random request lines while the instance is busy; these must be ignored.
    task automatic junk(input int d, input logic v);
        valid_a[d] = v;
        rd_a[d]    = 1'($urandom);
        wr_a[d]    = 1'($urandom);
        addr_a[d]  = $urandom;
        wdata_a[d] = $urandom;
        mode_a[d]  = 2'($urandom);
        sext_a[d]  = 1'($urandom);
    endtask

    task automatic check_reset_state(input int d, input string pfx);
        chk({pfx, "_good"},   32'(good_a[d]), 32'h0);
        chk({pfx, "_mis"},    32'(mis_a[d]),  32'h0);
        chk({pfx, "_rdata"},  rdata_a[d],     32'h0);
        chk({pfx, "_dmr"},    32'(dmr_a[d]),  32'h0);
        chk({pfx, "_dmw"},    32'(dmw_a[d]),  32'h0);
        chk({pfx, "_dmaddr"}, dmaddr_a[d],    32'h0);
        chk({pfx, "_dmdout"}, dmdout_a[d],    32'h0);
    endtask

    // One complete request on instance d, starting in an IDLE cycle.
    task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] m, input logic sx,
                       input logic [31:0] mem);
        int          ws;
        int          sz;
        int          lo;
        logic        op;
        logic        ok;
        int          emask;
        logic [31:0] edout;
        logic [31:0] vmask;
        logic [31:0] erd;
        ws = ws_of(d);
        sz = (m == 2'd0) ? 1 : ((m == 2'd1) ? 2 : 4);
        lo = int'(a[1:0]);
        op = r | w;
        ok = ((lo % sz) == 0);
        emask = ((1 << sz) - 1) << lo;
        case (sz)
            1:       edout = {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       edout = {16'h0, wd[15:0]} * 32'h0001_0001;
            default: edout = wd;
        endcase
        vmask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        erd = (mem >> (8 * lo)) & vmask;
        if (sx && sz < 4 && erd[8 * sz - 1]) erd = erd | ~vmask;
        if (!(op && ok)) erd = 32'h0;

        valid_a[d] = 1'b1;
        rd_a[d]    = r;
        wr_a[d]    = w;
        addr_a[d]  = a;
        wdata_a[d] = wd;
        mode_a[d]  = m;
        sext_a[d]  = sx;
        dmdin_a[d] = $urandom;
        tick();
        if (op && ok) begin
            last_addr[d] = a & 32'hFFFF_FFFC;
            for (int k = 0; k < ws; k++) begin
                chk("acc_good", 32'(good_a[d]), 32'h0);
                chk("acc_dmr",  32'(dmr_a[d]),  w ? 32'h0 : 32'h1);
                chk("acc_dmw",  32'(dmw_a[d]),  w ? 32'(emask) : 32'h0);
                chk("acc_addr", dmaddr_a[d],    last_addr[d]);
                if (w) chk("acc_dout", dmdout_a[d], edout);
                junk(d, 1'($urandom));
                // Only the value present on the final ACCESS edge may be used.
                dmdin_a[d] = (k == ws - 1) ? mem : $urandom;
                tick();
            end
        end
        chk("resp_good", 32'(good_a[d]), 32'h1);
        chk("resp_mis",  32'(mis_a[d]),  (op && !ok) ? 32'h1 : 32'h0);
        chk("resp_dmr",  32'(dmr_a[d]),  32'h0);
        chk("resp_dmw",  32'(dmw_a[d]),  32'h0);
        chk("resp_addr", dmaddr_a[d],    last_addr[d]);
        if (!(op && ok && w)) chk("resp_rdata", rdata_a[d], erd);
        junk(d, 1'b1);
        tick();
        chk("idle_good", 32'(good_a[d]), 32'h0);
        chk("idle_mis",  32'(mis_a[d]),  32'h0);
        chk("idle_dmw",  32'(dmw_a[d]),  32'h0);
        if (!(op && ok && w)) chk("idle_rdata", rdata_a[d], erd);
        quiet(d);
    endtask

    // Watchdog so the run ends even if the clock loop is broken.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          d;
        int          cyc;
        int          ngood;
        int          last_cyc;
        logic [31:0] prev_din;

        for (int i = 0; i < ND; i++) begin
            quiet(i);
            last_addr[i] = 32'h0;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < ND; i++) check_reset_state(i, "rst");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases, the first one accepted on the first edge after reset.
        txn(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0);
        txn(1, 1'b1, 1'b0, 32'h23, 32'h0,         2'd0, 1'b1, 32'h80FF_0011);
        txn(0, 1'b0, 1'b1, 32'h42, 32'h0000_ABCD, 2'd1, 1'b0, 32'h0);
        txn(0, 1'b1, 1'b0, 32'h42, 32'h0,         2'd1, 1'b0, 32'hABCD_1234);
        txn(0, 1'b1, 1'b0, 32'h6,  32'h0,         2'd2, 1'b0, 32'h1234_5678);
        txn(2, 1'b0, 1'b0, 32'h8,  32'h0,         2'd2, 1'b0, 32'h0);
        txn(1, 1'b1, 1'b1, 32'h31, 32'h0000_00A5, 2'd0, 1'b0, 32'h0);
        txn(2, 1'b1, 1'b0, 32'h3,  32'h0,         2'd1, 1'b1, 32'h0);

        // Random requests across all three wait-state settings.
        for (int n = 0; n < 40; n++) begin
            txn($urandom_range(0, 2), 1'($urandom), 1'($urandom), $urandom & 32'h0000_FFFF,
                $urandom, 2'($urandom), 1'($urandom), $urandom);
        end

        // Reset during the second ACCESS cycle of a word store (4 wait states).
        d = 2;
        valid_a[d] = 1'b1;
        wr_a[d]    = 1'b1;
        rd_a[d]    = 1'b0;
        addr_a[d]  = 32'h80;
        wdata_a[d] = $urandom;
        mode_a[d]  = 2'd2;
        tick();
        valid_a[d] = 1'b0;
        chk("abort_dmw_c1", 32'(dmw_a[d]), 32'hF);
        tick();
        chk("abort_dmw_c2", 32'(dmw_a[d]), 32'hF);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state(d, "abort");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < ND; i++) last_addr[i] = 32'h0;
        for (int k = 0; k < ws_of(d) + 2; k++) begin
            chk("abort_nogood", 32'(good_a[d]), 32'h0);
            tick();
        end
        txn(d, 1'b0, 1'b1, 32'h84, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h0);
        txn(d, 1'b1, 1'b0, 32'h86, 32'h0, 2'd1, 1'b1, 32'h9234_5678);

        // valid held high over three word loads (3 wait states).
        d = 1;
        valid_a[d] = 1'b1;
        rd_a[d]    = 1'b1;
        wr_a[d]    = 1'b0;
        addr_a[d]  = 32'h100;
        mode_a[d]  = 2'd2;
        ngood      = 0;
        last_cyc   = 0;
        prev_din   = 32'h0;
        cyc        = 0;
        while (ngood < 3 && cyc < 3 * (ws_of(d) + 2) + 6) begin
            if (good_a[d] === 1'b1) begin
                chk("b2b_rdata", rdata_a[d], prev_din);
                if (ngood == 0) chk("b2b_first", 32'(cyc), 32'(ws_of(d) + 1));
                else            chk("b2b_space", 32'(cyc - last_cyc), 32'(ws_of(d) + 2));
                last_cyc = cyc;
                ngood++;
                if (ngood == 3) valid_a[d] = 1'b0;
            end
            prev_din   = $urandom;
            dmdin_a[d] = prev_din;
            tick();
            cyc++;
        end
        chk("b2b_count", 32'(ngood), 32'h3);
        quiet(d);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
